rf_writeback: RTL and testbench

- Write-side master for the 16-entry register file: owns the single waddr/wdata/wea write port.
- Merges two result sources:
  - ALU results: one per cycle, no backpressure, highest priority.
  - Load results: valid/ready handshake.
- Load results that lose arbitration are held in a small in-order FIFO.
- Stale load results are killed by younger ALU writes to the same register.
- Exports a pending-register mask for the hazard/stall logic.

---
 rtl/rf_writeback.sv | 146 ++++++++++++++
 tb/tb_rf_writeback.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - register file write-port master merging ALU and load results
// Optional same-cycle forwarding ports are enabled by defining RF_WB_BYPASS_EN.
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_waddr,
    input  logic [DW-1:0]            alu_wdata,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [AW-1:0]            ld_waddr,
    input  logic [DW-1:0]            ld_wdata,
    output logic [AW-1:0]            waddr,
    output logic [DW-1:0]            wdata,
    output logic                     wea,
`ifdef RF_WB_BYPASS_EN
    input  logic [AW-1:0]            byp_r0addr,
    input  logic [AW-1:0]            byp_r1addr,
    output logic                     byp_r0hit,
    output logic                     byp_r1hit,
    output logic [DW-1:0]            byp_r0data,
    output logic [DW-1:0]            byp_r1data,
`endif
    output logic [2**AW-1:0]         pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2**AW;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wea_q, wea_d;

    logic accept, fifo_empty, pop, push, cut, push_live;

    assign ld_ready   = (count_q < CW'(DEPTH)) & ~reset;
    assign accept     = ld_valid & ld_ready;
    assign fifo_empty = (count_q == '0);

    // Priority: ALU, then FIFO head, then cut-through of the offered load.
    always_comb begin
        pop     = 1'b0;
        cut     = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wea_d   = 1'b0;
        if (alu_valid) begin
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
            wea_d   = 1'b1;
        end else if (!fifo_empty) begin
            pop   = 1'b1;
            wea_d = live_q[head_q];
            if (live_q[head_q]) begin
                waddr_d = addr_q[head_q];
                wdata_d = data_q[head_q];
            end
        end else if (accept) begin
            cut     = 1'b1;
            waddr_d = ld_waddr;
            wdata_d = ld_wdata;
            wea_d   = 1'b1;
        end
    end

    assign push      = accept & ~cut;
    // A load arriving alongside an ALU write to the same register is older, so it is born dead.
    assign push_live = ~(alu_valid & (ld_waddr == alu_waddr));

    always_comb begin
        live_d = live_q;
        if (alu_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == alu_waddr) live_d[i] = 1'b0;
            end
        end
        if (pop)  live_d[head_q] = 1'b0;
        if (push) live_d[tail_q] = push_live;
    end

    assign head_d  = pop  ? head_q + PW'(1) : head_q;
    assign tail_d  = push ? tail_q + PW'(1) : tail_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wea_q   <= 1'b0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wea_q   <= wea_d;
        end
    end

    // Payload slots need no reset: the live bits and occupancy qualify them.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= ld_waddr;
            data_q[tail_q] <= ld_wdata;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pending_mask[addr_q[i]] = 1'b1;
        end
    end

    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign wea        = wea_q;
    assign fifo_count = count_q;

`ifdef RF_WB_BYPASS_EN
    assign byp_r0hit  = wea_q & (waddr_q == byp_r0addr);
    assign byp_r1hit  = wea_q & (waddr_q == byp_r1addr);
    assign byp_r0data = wdata_q;
    assign byp_r1data = wdata_q;
`endif

    logic unused_nr;
    assign unused_nr = (NR == 0);

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - randomized queue-model bench for rf_writeback
module tb_rf_writeback;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, ld_valid, ld_ready, wea;
    logic [AW-1:0] alu_waddr, ld_waddr, waddr;
    logic [DW-1:0] alu_wdata, ld_wdata, wdata;
    logic [15:0]   pending_mask;
    logic [2:0]    fifo_count;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] byp_r0addr, byp_r1addr;
    logic          byp_r0hit, byp_r1hit;
    logic [DW-1:0] byp_r0data, byp_r1data;
`endif

    always #5 clk = ~clk;

    rf_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .waddr(waddr), .wdata(wdata), .wea(wea),
`ifdef RF_WB_BYPASS_EN
        .byp_r0addr(byp_r0addr), .byp_r1addr(byp_r1addr),
        .byp_r0hit(byp_r0hit), .byp_r1hit(byp_r1hit),
        .byp_r0data(byp_r0data), .byp_r1data(byp_r1data),
`endif
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          mq[$];
    logic          m_wea;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            checks = 0;
    int            failures = 0;
    bit            chk_en = 0;
    bit            acc;
    int            li;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wea   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wea", wea, m_wea);
            if (m_wea) begin
                chk("waddr", waddr, m_waddr);
                chk("wdata", wdata, m_wdata);
            end
            chk("fifo_count", fifo_count, mq.size());
            chk("pending_mask", pending_mask, model_mask());
            chk("ld_ready", ld_ready, (!reset && mq.size() < DEPTH));
        end
    end

    // Drive one cycle of inputs, advance the model to the state after the next edge.
    task automatic cyc(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                       output bit accepted);
        bit   cut = 0;
        ent_t e;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        ld_valid  = lv; ld_waddr  = la; ld_wdata  = ldd;
        accepted  = lv && (mq.size() < DEPTH);
        if (av) begin
            m_wea = 1'b1; m_waddr = aa; m_wdata = ad;
            foreach (mq[i]) if (mq[i].a == aa) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wea = e.live;
            if (e.live) begin m_waddr = e.a; m_wdata = e.d; end
        end else if (accepted) begin
            cut = 1; m_wea = 1'b1; m_waddr = la; m_wdata = ldd;
        end else begin
            m_wea = 1'b0;
        end
        if (accepted && !cut) mq.push_back('{a: la, d: ldd, live: !(av && la == aa)});
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, '0, '0, 0, '0, '0, acc);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; alu_waddr = '0; alu_wdata = '0;
        ld_valid = 0; ld_waddr = '0; ld_wdata = '0;
`ifdef RF_WB_BYPASS_EN
        byp_r0addr = '0; byp_r1addr = '0;
`endif
        model_reset();
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wea", wea, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", ld_ready, 0);
        reset = 1'b0;

        // ALU only, then asynchronous reset mid-cycle
        cyc(1, 4'd3, 32'hDEADBEEF, 0, '0, '0, acc);
        chk("alu_wea", wea, 1);
        chk("alu_waddr", waddr, 3);
        chk("alu_wdata", wdata, 32'hDEADBEEF);
        idle();
        chk("alu_idle_wea", wea, 0);
        cyc(1, 4'd9, 32'h1234, 0, '0, '0, acc);
        chk("pre_async_wea", wea, 1);
        #2 reset = 1'b1;
        model_reset();
        #1 chk("async_rst_wea", wea, 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // Cut-through
        cyc(0, '0, '0, 1, 4'd5, 32'h11, acc);
        chk("cut_wea", wea, 1);
        chk("cut_waddr", waddr, 5);
        chk("cut_wdata", wdata, 32'h11);
        chk("cut_count", fifo_count, 0);

        // Contention fill: r1..r6 ALU, loads r8..r13 offered
        li = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(1, AW'(c + 1), $urandom, li < 6, AW'(8 + li), 32'h100 + li, acc);
            if (acc) li++;
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_mask", pending_mask, 16'h0F00);
        chk("fill_ready", ld_ready, 0);
        cyc(0, '0, '0, li < 6, AW'(8 + li), 32'h100 + li, acc);
        if (acc) li++;
        chk("drain_first_waddr", waddr, 8);
        chk("drain_first_wdata", wdata, 32'h100);
        for (int c = 0; c < 10; c++) begin
            cyc(0, '0, '0, li < 6, AW'(8 + li), 32'h100 + li, acc);
            if (acc) li++;
        end
        chk("drain_count", fifo_count, 0);

        // Kill
        cyc(1, 4'd1, 32'h55, 1, 4'd7, 32'hAA, acc);
        chk("kill_mask_set", pending_mask, 16'h0080);
        cyc(1, 4'd7, 32'hBB, 0, '0, '0, acc);
        chk("kill_mask_clr", pending_mask, 16'h0000);
        chk("kill_wdata", wdata, 32'hBB);
        chk("kill_count", fifo_count, 1);
        idle();
        chk("kill_bubble_wea", wea, 0);
        chk("kill_bubble_count", fifo_count, 0);

        // Full FIFO, push attempt during pop
        for (int c = 0; c < 4; c++) cyc(1, AW'(c + 1), $urandom, 1, AW'(10 + c), $urandom, acc);
        chk("full_ready", ld_ready, 0);
        cyc(0, '0, '0, 1, 4'd14, 32'hEE, acc);
        chk("full_pop_count", fifo_count, 3);
        repeat (4) idle();

        // Same-cycle ALU and load to r2
        cyc(1, 4'd2, 32'h2222, 1, 4'd2, 32'h3333, acc);
        chk("coll_wdata", wdata, 32'h2222);
        chk("coll_count", fifo_count, 1);
        chk("coll_mask", pending_mask, 16'h0000);
        idle();
        chk("coll_bubble_wea", wea, 0);

`ifdef RF_WB_BYPASS_EN
        cyc(1, 4'd3, 32'hCAFE, 0, '0, '0, acc);
        byp_r0addr = 4'd3;
        byp_r1addr = 4'd4;
        #1;
        chk("byp_r0hit", byp_r0hit, 1);
        chk("byp_r0data", byp_r0data, 32'hCAFE);
        chk("byp_r1hit", byp_r1hit, 0);
`endif

        // Randomized traffic over a few registers so kills are frequent
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                reset = 1'b1;
                model_reset();
                @(negedge clk); #1;
                reset = 1'b0;
            end
            cyc($urandom_range(0, 1), AW'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 2) != 0, AW'($urandom_range(0, 3)), $urandom, acc);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
